score_keeper: RTL
=================

# score_keeper

Score tracking and serve sequencing for the pong datapath. Turns ball-out-of-bounds events from the ball logic into the player and enemy score counts that `game_fsm` watches for game end. Holds the ball in a timed serve pause after every point and reports the winner once a side reaches the maximum score. Sits between the ball/collision logic (the event source) and `game_fsm`/score display (the consumers).

## Interface
- `MAX_SCORE`, default `score_pkg::MAX_SCORE`: winning score; the game ends when either count reaches it.
- `SERVE_FRAMES`, default 60: frames of serve pause after game start and after each point; must be ≥1.
- `M_SCORE_W`, from `score_pkg`: score width; `MAX_SCORE` must fit in it.
- `clk_i` in 1: system clock. Single clock domain.
- `rst_i` in 1: reset, synchronous, active-high.
- `game_rst_i` in 1: one-cycle new-game pulse; the same pulse that drives `game_fsm`.
- `game_en_i` in 1: `game_en_o` from `game_fsm`.
- `frame_tick_i` in 1: one-cycle pulse per video frame.
- `p_goal_i` in 1: ball left the enemy side, so the player scores. Level or pulse; edge-detected internally.
- `e_goal_i` in 1: ball left the player side, so the enemy scores. Level or pulse; edge-detected internally.
- `p_score_o` out `M_SCORE_W`: player score, registered.
- `e_score_o` out `M_SCORE_W`: enemy score, registered.
- `serve_o` out 1: ball must be held at its serve position, registered.
- `ball_rst_o` out 1: one-cycle pulse that recentres the ball, registered.
- `winner_o` out 2: 00 none, 01 player, 10 enemy; registered.

## Operation
- States:
  - `IDLE`: after reset, before the first game.
  - `SERVE`: timed pause before play.
  - `RALLY`: ball in play.
  - `OVER`: a side has reached `MAX_SCORE`.
- Reset values: state `IDLE`; scores 0; `serve_o`=1; `ball_rst_o`=0; `winner_o`=00; frame counter 0; goal edge registers 0.
- `game_rst_i`=1 in any state:
  - Clear both scores and `winner_o`.
  - Load the frame counter with `SERVE_FRAMES-1`.
  - Pulse `ball_rst_o`.
  - Go to `SERVE`.
  - This has priority over every other event in the same cycle, including goals.
- `SERVE`:
  - `serve_o`=1.
  - Each `frame_tick_i` decrements the counter.
  - A tick arriving with the counter at 0 moves the FSM to `RALLY`, so the pause is exactly `SERVE_FRAMES` ticks.
- `RALLY`:
  - `serve_o`=0.
  - Goal edge = input high this cycle and low the previous cycle. A goal is accepted only when `game_en_i`=1.
  - Exactly one edge: increment that side's score. The increment saturates at `MAX_SCORE`; the score never wraps.
  - If the new score equals `MAX_SCORE`: go to `OVER` and set `winner_o` to the scoring side.
  - Otherwise: reload the counter, pulse `ball_rst_o`, and go to `SERVE`.
  - Both edges in the same cycle: no score change; pulse `ball_rst_o`, reload the counter, go to `SERVE` (point replayed).
- `OVER`:
  - `serve_o`=1; scores and `winner_o` held.
  - Goals and ticks are ignored.
  - Leaves only on `game_rst_i`.
- Goal edges in `IDLE`, `SERVE`, `OVER`, or with `game_en_i`=0 are discarded. The edge registers still track the inputs, so a level already high when `RALLY` is entered does not count.
- `frame_tick_i` is ignored outside `SERVE`.
- `rst_i` mid-game returns every register to its reset value on the next edge.

## Timing
- Goal edge sampled at clock edge k: the score, `ball_rst_o`, `winner_o` and the state change are all visible after edge k (one-cycle latency from the first high cycle of the goal input).
- `ball_rst_o` is high for exactly one cycle per new game or point.
- `serve_o` falls in the cycle after the final serve tick is sampled.
- `game_fsm` sees `MAX_SCORE` on the score output in the same cycle `winner_o` becomes valid.

## Test plan
All scenarios use `MAX_SCORE`=3, `SERVE_FRAMES`=2, `game_en_i`=1.
- Reset, then no stimulus → scores 0, `serve_o`=1, `winner_o`=00, `ball_rst_o` never pulses.
- `game_rst_i` pulse, then ticks → `ball_rst_o` one-cycle pulse; `serve_o` stays 1 through the 1st tick and falls after the 2nd tick.
- In `RALLY`, `p_goal_i` held high 5 cycles → `p_score_o`=1 after one cycle, a single `ball_rst_o` pulse, back in `SERVE`. A level still high when the next `RALLY` starts → no second point.
- Player scores 3 points in separate rallies → `p_score_o`=3, `winner_o`=01, `serve_o`=1. A further `e_goal_i` edge → `e_score_o` unchanged. `game_rst_i` → both scores 0, `winner_o`=00.
- `p_goal_i` and `e_goal_i` rise in the same cycle during `RALLY` → both scores unchanged, `ball_rst_o` pulse, `SERVE`.
- Goal edge coincident with `game_rst_i` → scores 0 (reset wins). Also: `rst_i` mid-serve → all outputs return to their reset values one cycle later.

Source files
------------

// File: rtl/score_keeper.sv
// Score tracking and serve sequencing for the pong datapath: counts goals,
// times the serve pause after each point and reports the winner.
package score_pkg;
  localparam int M_SCORE_W = 4;
  localparam int MAX_SCORE = 11;
endpackage

module score_keeper #(
  parameter int MAX_SCORE    = score_pkg::MAX_SCORE,
  parameter int SERVE_FRAMES = 60,
  parameter int M_SCORE_W    = score_pkg::M_SCORE_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 game_rst_i,
  input  logic                 game_en_i,
  input  logic                 frame_tick_i,
  input  logic                 p_goal_i,
  input  logic                 e_goal_i,
  output logic [M_SCORE_W-1:0] p_score_o,
  output logic [M_SCORE_W-1:0] e_score_o,
  output logic                 serve_o,
  output logic                 ball_rst_o,
  output logic [1:0]           winner_o,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RALLY = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0]     CNT_LOAD  = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]     CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic [M_SCORE_W-1:0] SCORE_MAX = M_SCORE_W'(MAX_SCORE);
  localparam logic [M_SCORE_W-1:0] SCORE_ONE = M_SCORE_W'(1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [M_SCORE_W-1:0] p_score_q, p_score_d;
  logic [M_SCORE_W-1:0] e_score_q, e_score_d;
  logic [1:0]           winner_q, winner_d;
  logic                 serve_q, serve_d;
  logic                 ball_rst_q, ball_rst_d;
  logic                 p_goal_q, e_goal_q;
  logic                 p_edge, e_edge;
  logic [M_SCORE_W-1:0] p_inc, e_inc;

  // Edge registers always follow the inputs so a level held across a serve
  // cannot score again when the rally starts.
  assign p_edge = p_goal_i & ~p_goal_q;
  assign e_edge = e_goal_i & ~e_goal_q;
  assign p_inc  = (p_score_q >= SCORE_MAX) ? SCORE_MAX : p_score_q + SCORE_ONE;
  assign e_inc  = (e_score_q >= SCORE_MAX) ? SCORE_MAX : e_score_q + SCORE_ONE;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_score_d  = p_score_q;
    e_score_d  = e_score_q;
    winner_d   = winner_q;
    ball_rst_d = 1'b0;

    if (game_rst_i) begin
      p_score_d  = '0;
      e_score_d  = '0;
      winner_d   = 2'b00;
      cnt_d      = CNT_LOAD;
      ball_rst_d = 1'b1;
      state_d    = SERVE;
    end else begin
      case (state_q)
        SERVE: begin
          if (frame_tick_i) begin
            if (cnt_q == CNT_ZERO) state_d = RALLY;
            else                   cnt_d   = cnt_q - CNT_ONE;
          end
        end
        RALLY: begin
          if (game_en_i && (p_edge || e_edge)) begin
            if (p_edge && e_edge) begin
              cnt_d      = CNT_LOAD;
              ball_rst_d = 1'b1;
              state_d    = SERVE;
            end else if (p_edge) begin
              p_score_d = p_inc;
              if (p_inc == SCORE_MAX) begin
                winner_d = 2'b01;
                state_d  = OVER;
              end else begin
                cnt_d      = CNT_LOAD;
                ball_rst_d = 1'b1;
                state_d    = SERVE;
              end
            end else begin
              e_score_d = e_inc;
              if (e_inc == SCORE_MAX) begin
                winner_d = 2'b10;
                state_d  = OVER;
              end else begin
                cnt_d      = CNT_LOAD;
                ball_rst_d = 1'b1;
                state_d    = SERVE;
              end
            end
          end
        end
        default: ;
      endcase
    end

    serve_d = (state_d != RALLY);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      p_score_q  <= '0;
      e_score_q  <= '0;
      winner_q   <= 2'b00;
      serve_q    <= 1'b1;
      ball_rst_q <= 1'b0;
      p_goal_q   <= 1'b0;
      e_goal_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_score_q  <= p_score_d;
      e_score_q  <= e_score_d;
      winner_q   <= winner_d;
      serve_q    <= serve_d;
      ball_rst_q <= ball_rst_d;
      p_goal_q   <= p_goal_i;
      e_goal_q   <= e_goal_i;
    end
  end

  assign p_score_o   = p_score_q;
  assign e_score_o   = e_score_q;
  assign serve_o     = serve_q;
  assign ball_rst_o  = ball_rst_q;
  assign winner_o    = winner_q;
  assign dbg_state_o = state_q;

endmodule
